// File: rtl/mon_pkg.sv
// Shared types for the output-side capture monitor: the FIFO entry record and FSM states.
package mon_pkg;
    localparam int MON_WIDTH = 1;
    localparam int MON_TS_W  = 32;

    typedef struct packed {
        logic [MON_TS_W-1:0]  ts;
        logic [MON_WIDTH-1:0] data;
    } mon_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mon_state_e;
endpackage

// File: rtl/mon_fifo.sv
// Synchronous FIFO with registered read port; a pop frees its slot before a same-cycle push is judged.
module mon_fifo
    import mon_pkg::*;
#(
    parameter type entry_t = mon_entry_t,
    parameter int  DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  entry_t             wdata,
    input  logic               pop,
    output entry_t             rdata,
    output logic               rvalid,
    output logic               drop,
    output logic [$clog2(DEPTH):0] count,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= pop_ok;
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok) begin
                rptr  <= rptr + AW'(1);
                rdata <= mem[rptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mon_capture.sv
// Records every change of a monitored DUT output with a cycle timestamp and hands the
// records to a reader through a registered pop handshake.
module mon_capture
    import mon_pkg::*;
#(
    parameter int ID    = 1,
    parameter int WIDTH = 1,
    parameter int DEPTH = 16,
    parameter int TS_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       sample,
    input  logic                   rd_en,
    output logic                   rd_valid,
    output logic [TS_W-1:0]        rd_ts,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   overflow,
    input  logic                   clr_ovf
);
    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [WIDTH-1:0] data;
    } entry_t;

    // Instance id only matters to the software side; kept visible as a constant net.
    logic [31:0] id_unused;
    assign id_unused = ID;

    mon_state_e       state;
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] last_q;
    logic             push;
    logic             drop;
    logic             full;
    entry_t           wdata;
    entry_t           rdata;

    always_comb begin
        push = 1'b0;
        case (state)
            IDLE:    push = en;
            RUN:     push = en && (sample != last_q);
            default: push = 1'b0;
        endcase
    end

    assign wdata = '{ts: ts, data: sample};

    // last_q follows the sample even when the push is dropped, so the next
    // recorded change is relative to what the DUT actually showed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ts       <= '0;
            last_q   <= '0;
            overflow <= 1'b0;
        end else begin
            ts    <= ts + TS_W'(1);
            state <= en ? RUN : IDLE;
            if (en) last_q <= sample;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    mon_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wdata  (wdata),
        .pop    (rd_en),
        .rdata  (rdata),
        .rvalid (rd_valid),
        .drop   (drop),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    assign rd_ts   = rdata.ts;
    assign rd_data = rdata.data;
endmodule

// File: tb/tb_mon_capture.sv
// Randomised and directed bench for mon_capture: a queue-based reference model feeds a
// scoreboard that is drained by an independent monitor on the falling edge.
module tb_mon_capture;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int TS_W  = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] sample;
    logic             rd_en;
    logic             clr_ovf;
    logic             rd_valid;
    logic [TS_W-1:0]  rd_ts;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    count;
    logic             empty;
    logic             overflow;

    mon_capture #(.ID(3), .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sample   (sample),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_ts    (rd_ts),
        .rd_data  (rd_data),
        .count    (count),
        .empty    (empty),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ts;
        int data;
    } ent_t;

    int   errors = 0;
    int   checks = 0;
    ent_t q[$];      // what the FIFO should hold
    ent_t expq[$];   // popped entries the DUT owes the reader
    ent_t held;
    int   mts;
    bit   men;
    int   mlast;
    bit   movf;
    bit   mvalid;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: capture rules evaluated at each rising edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                expq.delete();
                mts = 0; men = 0; mlast = 0; movf = 0; mvalid = 0;
                held = '{0, 0};
            end else begin
                bit want;
                bit dropped;
                mvalid = 0;
                if (rd_en && q.size() > 0) begin
                    expq.push_back(q.pop_front());
                    mvalid = 1;
                end
                want = en && (!men || int'(sample) != mlast);
                dropped = 0;
                if (want) begin
                    if (q.size() < DEPTH) q.push_back('{mts, int'(sample)});
                    else dropped = 1;
                end
                if (en) mlast = int'(sample);
                men = en;
                if (dropped) movf = 1;
                else if (clr_ovf) movf = 0;
                mts = (mts + 1) % (1 << TS_W);
            end
        end
    end

    // Monitor: compare DUT outputs with the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rd_valid", rd_valid, mvalid);
                if (rd_valid) begin
                    if (expq.size() == 0) chk("rd_unexpected", 1, 0);
                    else begin
                        held = expq.pop_front();
                        chk("rd_ts", rd_ts, held.ts);
                        chk("rd_data", rd_data, held.data);
                    end
                end else begin
                    chk("rd_ts_hold", rd_ts, held.ts);
                    chk("rd_data_hold", rd_data, held.data);
                end
                chk("count", count, q.size());
                chk("empty", empty, q.size() == 0);
                chk("overflow", overflow, movf);
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; sample = '0; rd_en = 1'b0; clr_ovf = 1'b0;
        cyc(3);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_overflow", overflow, 0);
        rst = 1'b1;

        // change capture: en from cycle 2, toggles at 5 and 9
        cyc(2); en = 1'b1;
        cyc(3); sample = 8'd1;
        cyc(4); sample = 8'd0;
        cyc(1);
        chk("three_entries", count, 3);
        rd_en = 1'b1;
        cyc(1); chk("first_ts", rd_ts, 2); chk("first_data", rd_data, 0);
        cyc(1); chk("second_ts", rd_ts, 5); chk("second_data", rd_data, 1);
        cyc(1); chk("third_ts", rd_ts, 9); chk("third_data", rd_data, 0);
        rd_en = 1'b0;

        // overflow: 20 changes, no reads
        for (int i = 1; i <= 20; i++) begin
            sample = WIDTH'(i);
            cyc(1);
        end
        cyc(1);
        chk("full_count", count, 16);
        chk("ovf_set", overflow, 1);
        clr_ovf = 1'b1; cyc(1); clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);

        // pop and push together while full
        sample = 8'd99; rd_en = 1'b1; cyc(1); rd_en = 1'b0;
        chk("full_pushpop_count", count, 16);
        chk("full_pushpop_ovf", overflow, 0);
        rd_en = 1'b1; cyc(16);
        chk("last_out", rd_data, 99);
        cyc(1);
        chk("empty_rd_valid", rd_valid, 0);
        chk("empty_rd_count", count, 0);
        rd_en = 1'b0;

        // re-enable records the new value as an initial entry
        en = 1'b0; cyc(1);
        sample = 8'd7; cyc(1);
        en = 1'b1; cyc(1);
        chk("reenable_count", count, 1);
        rd_en = 1'b1; cyc(1); rd_en = 1'b0;
        chk("reenable_data", rd_data, 7);

        // async reset with 5 entries stored
        for (int i = 0; i < 5; i++) begin
            sample = WIDTH'(40 + i);
            cyc(1);
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_rd_ts", rd_ts, 0);
        chk("arst_rd_data", rd_data, 0);
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_overflow", overflow, 0);
        cyc(2);
        rst = 1'b1; en = 1'b1; sample = 8'h33;
        cyc(1); rd_en = 1'b1; cyc(1); rd_en = 1'b0;
        chk("post_rst_ts", rd_ts, 0);
        chk("post_rst_data", rd_data, 8'h33);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            en      = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 2) == 0) sample = WIDTH'($urandom_range(0, 3));
            rd_en   = ($urandom_range(0, 3) == 0);
            clr_ovf = ($urandom_range(0, 19) == 0);
            if (i == 700) begin
                #2 rst = 1'b0;
                cyc(1);
                rst = 1'b1;
            end else begin
                cyc(1);
            end
        end
        en = 1'b0; clr_ovf = 1'b0; rd_en = 1'b1;
        cyc(DEPTH + 2);
        chk("final_drain", count, 0);
        rd_en = 1'b0;
        cyc(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mon_capture.md
# mon_capture

Output-side monitor that watches a DUT output each clock, records every value change with a cycle timestamp into an internal FIFO, and lets the scenario/DPI-C side drain those records through a simple read handshake. It is the receiving end opposite the stimulus drivers: drivers push values into the DUT, and `mon_capture` returns what the DUT produced. One instance sits beside the DUT in each bench top and is identified by `ID` for s2cif routing.

## Interface
- `ID`, 1: instance identifier, reported in debug prints and s2cif routing.
- `WIDTH`, 1: width of the monitored signal.
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `TS_W`, 32: timestamp width.

- `clk` in 1: sampling clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: capture enable.
- `sample` in WIDTH: monitored DUT output (e.g. `dout`).
- `rd_en` in 1: pop request from the reader side.
- `rd_valid` out 1: `rd_ts`/`rd_data` hold a popped entry this cycle.
- `rd_ts` out TS_W: timestamp of the popped entry.
- `rd_data` out WIDTH: sampled value of the popped entry.
- `count` out $clog2(DEPTH)+1: entries currently stored.
- `empty` out 1: count == 0.
- `overflow` out 1: sticky; at least one entry was dropped.
- `clr_ovf` in 1: clears `overflow`.

## Operation
- Free-running `ts` counter: 0 after reset, +1 every cycle, wraps modulo 2^TS_W. No enable gating.
- FSM states: IDLE, RUN.
  - IDLE: when `en`=1, push {ts, sample} unconditionally (initial value), load `last_q`=sample, go to RUN.
  - RUN: if `en`=0, go to IDLE (no push). Otherwise, if sample != last_q, push {ts, sample} and update `last_q`.
- Push when full: entry dropped, `overflow` set, `last_q` still updated. The next change is recorded against the new value.
- Push and pop in the same cycle while full: pop frees the slot first, so the push is accepted and `overflow` is not set.
- `rd_en` while empty: ignored, `rd_valid` stays 0, no underflow.
- `clr_ovf` and a drop in the same cycle: `overflow` ends at 1 (set wins).
- Reset mid-operation: FIFO flushed, FSM goes to IDLE, `ts`=0. Pending data is lost.
- Reset values: `rd_valid`=0, `rd_ts`=0, `rd_data`=0, `count`=0, `empty`=1, `overflow`=0.

## Timing
- The sample is taken at rising edge N. The entry carries the `ts` value current before edge N. `count` reflects the push after edge N.
- The pop is registered. `rd_en`=1 at edge N gives `rd_valid`=1 with data during cycle N+1. `count` decrements after edge N. Back-to-back `rd_en` yields one entry per cycle.
- `rd_ts`/`rd_data` hold their last value when `rd_valid`=0.
- Change-to-FIFO latency is 1 cycle. With an idle reader, sample-to-`rd_valid` is at least 2 cycles.

## Structure
- Package `mon_pkg`:
  - typedef `mon_entry_t` struct {ts, data}, parameterised via localparams matching the defaults.
  - FSM enum `mon_state_e` {IDLE, RUN}.
- Sub-module `mon_fifo`: synchronous FIFO of `mon_entry_t` with push/pop, registered read data, count, full and empty, and same-cycle push/pop handling when full.
- `mon_capture` holds the FSM, `ts` counter, `last_q` and overflow logic.

## Test plan
- Reset, then `en`=1 with `sample`=0 held for 10 cycles -> exactly one entry {ts=first enabled cycle, data 0}, `count`=1.
- `sample` toggles 0→1 at cycle 5 and 1→0 at cycle 9 (en from cycle 2) -> three entries with ts 2, 5, 9 and data 0, 1, 0, popped in that order with `rd_valid` one cycle after each `rd_en`.
- DEPTH=16: generate 20 changes with no reads -> `count`=16, `overflow`=1, first 16 timestamps retained. `clr_ovf` -> `overflow`=0.
- FIFO full, then `rd_en` and a sample change in the same cycle -> `count` stays 16, `overflow` stays 0, and the new entry is last out.
- `rd_en` on empty FIFO -> `rd_valid`=0, `count`=0. Drop `en`, change `sample`, raise `en` -> a new initial entry carries the new value.
- Assert `rst`=0 asynchronously mid-run with 5 entries stored -> outputs return to reset values immediately. After release, `ts` restarts at 0.
